// File: rtl/ppu_ri_v2.sv
// ppu_ri_v2 -- CPU-facing PPU register file for $2000-$2007.
// Decodes one access per /CS falling edge. Holds the scroll, control and mask
// latches, the open-bus latch with decay, the sprite RAM pointer, the vblank
// flag (including the $2002 read race) and a handshaked, timeout-guarded
// $2007 read path with optional palette bypass.
module ppu_ri_v2 #(
    parameter int SPR_RAM_AW   = 8,
    parameter int DECAY_CYCLES = 30000000,
    parameter int RD_TIMEOUT   = 15,
    parameter int PAL_BYPASS   = 1
) (
    input  logic                  clk_in,
    input  logic                  nrst_in,
    input  logic [2:0]            sel_in,
    input  logic                  ncs_in,
    input  logic                  r_nw_in,
    input  logic [7:0]            cpu_d_in,
    output logic [7:0]            cpu_d_out,
    input  logic [13:0]           vram_a_in,
    input  logic [7:0]            vram_d_in,
    input  logic                  vram_rd_ack_in,
    output logic                  vram_rd_req_out,
    output logic [7:0]            vram_d_out,
    output logic                  vram_wr_out,
    input  logic                  vblank_in,
    input  logic                  spr_ovf_in,
    input  logic                  spr0_hit_in,
    input  logic [7:0]            spr_ram_d_in,
    output logic [SPR_RAM_AW-1:0] spr_ram_a_out,
    output logic [7:0]            spr_ram_d_out,
    output logic                  spr_ram_wr_out,
    output logic [2:0]            fv_out,
    output logic [4:0]            vt_out,
    output logic                  v_out,
    output logic [2:0]            fh_out,
    output logic [4:0]            ht_out,
    output logic                  h_out,
    output logic                  s_out,
    output logic                  spr_pt_out,
    output logic                  spr_h_out,
    output logic                  inc_addr_out,
    output logic                  inc_addr_amt_out,
    output logic                  nvbl_en_out,
    output logic                  bg_en_out,
    output logic                  spr_en_out,
    output logic                  bg_clip_out,
    output logic                  spr_clip_out,
    output logic                  upd_cntrs_out,
    output logic                  rd_busy_out
);

    localparam int DCW = $clog2(DECAY_CYCLES + 1);
    localparam int TCW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [DCW-1:0] DECAY_MAX  = DCW'(DECAY_CYCLES);
    localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(RD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_REQ  = 1'b1
    } rd_state_t;

    rd_state_t rd_state;

    logic                  q_ncs;
    logic                  q_vblank_in;
    logic                  q_vblank;
    logic                  q_spr0;
    logic                  q_ovf;
    logic                  q_byte_sel;
    logic [7:0]            q_open_bus;
    logic [DCW-1:0]        q_decay_cnt;
    logic [7:0]            q_cpu_d_out;
    logic [7:0]            q_rd_buf;
    logic                  q_pal_rd;
    logic [TCW-1:0]        q_to_cnt;
    logic [SPR_RAM_AW-1:0] q_spr_a;

    logic       trigger;
    logic       wr_trig;
    logic       rd_trig;
    logic       busy;
    logic       sel_2007;
    logic       bus_acc;
    logic       rd_2002;
    logic       rd_2007_acc;
    logic       wr_2007_acc;
    logic       ack_now;
    logic       vbl_rise;
    logic       pal_hit;
    logic       attr_sel;
    logic [7:0] spr_rd_data;
    logic [7:0] rd_data;
    logic       vram_a_unused;

    // Access decode: a trigger is the first clock in which /CS is seen low.
    // Reset gates the trigger and the handshake so nothing fires while held.
    assign trigger     = q_ncs & ~ncs_in & nrst_in;
    assign wr_trig     = trigger & ~r_nw_in;
    assign rd_trig     = trigger & r_nw_in;
    assign busy        = (rd_state == RD_REQ) & nrst_in;
    assign sel_2007    = (sel_in == 3'd7);
    assign bus_acc     = trigger & ~(sel_2007 & busy);
    assign rd_2002     = rd_trig & (sel_in == 3'd2);
    assign rd_2007_acc = rd_trig & sel_2007 & ~busy;
    assign wr_2007_acc = wr_trig & sel_2007 & ~busy;
    assign ack_now     = busy & vram_rd_ack_in;
    assign vbl_rise    = vblank_in & ~q_vblank_in;
    assign pal_hit     = (PAL_BYPASS != 0) && (vram_a_in[13:8] == 6'h3F);
    assign vram_a_unused = ^vram_a_in[7:0];

    // Attribute bytes (pointer[1:0]==2) have no storage in bits 4:2.
    assign attr_sel = (q_spr_a[1:0] == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_spr_mask
            if (gi >= 2 && gi <= 4) begin : g_masked
                assign spr_rd_data[gi] = spr_ram_d_in[gi] & ~attr_sel;
            end else begin : g_pass
                assign spr_rd_data[gi] = spr_ram_d_in[gi];
            end
        end
    endgenerate

    // Value a read trigger returns, selected by register number.
    always_comb begin
        rd_data = q_open_bus;
        case (sel_in)
            3'd2:    rd_data = {q_vblank, q_spr0, q_ovf, q_open_bus[4:0]};
            3'd4:    rd_data = spr_rd_data;
            3'd7:    rd_data = pal_hit ? q_open_bus : q_rd_buf;
            default: rd_data = q_open_bus;
        endcase
    end

    // Strobes that must appear in the trigger/ack clock itself.
    assign cpu_d_out       = (~ncs_in & r_nw_in) ? q_cpu_d_out : 8'h00;
    assign vram_wr_out     = wr_2007_acc;
    assign vram_d_out      = wr_2007_acc ? cpu_d_in : 8'h00;
    assign inc_addr_out    = wr_2007_acc | ack_now;
    assign spr_ram_wr_out  = wr_trig & (sel_in == 3'd4);
    assign spr_ram_d_out   = spr_ram_wr_out ? cpu_d_in : 8'h00;
    assign spr_ram_a_out   = q_spr_a;
    assign vram_rd_req_out = busy;
    assign rd_busy_out     = busy;

    // Chip-select history and per-clock sampling of the status inputs.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            q_ncs       <= 1'b1;
            q_vblank_in <= 1'b0;
            q_spr0      <= 1'b0;
            q_ovf       <= 1'b0;
        end else begin
            q_ncs       <= ncs_in;
            q_vblank_in <= vblank_in;
            q_spr0      <= spr0_hit_in;
            q_ovf       <= spr_ovf_in;
        end
    end

    // Vblank flag: a $2002 read landing on the rising edge suppresses it.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            q_vblank <= 1'b0;
        end else if (!vblank_in) begin
            q_vblank <= 1'b0;
        end else if (rd_2002) begin
            q_vblank <= 1'b0;
        end else if (vbl_rise) begin
            q_vblank <= 1'b1;
        end
    end

    // Open-bus latch: reloaded by every serviced access, cleared after decay.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            q_open_bus  <= 8'h00;
            q_decay_cnt <= '0;
        end else if (bus_acc) begin
            q_open_bus  <= r_nw_in ? rd_data : cpu_d_in;
            q_decay_cnt <= '0;
        end else if (q_decay_cnt != DECAY_MAX) begin
            q_decay_cnt <= q_decay_cnt + 1'b1;
            if (q_decay_cnt == DECAY_LAST) begin
                q_open_bus <= 8'h00;
            end
        end
    end

    // CPU read-data latch; a palette-bypass read is refreshed on the ack.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            q_cpu_d_out <= 8'h00;
        end else if (bus_acc && r_nw_in) begin
            q_cpu_d_out <= rd_data;
        end else if (ack_now && q_pal_rd) begin
            q_cpu_d_out <= vram_d_in;
        end
    end

    // Control, mask and scroll latches with the shared $2005/$2006 toggle.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            fv_out           <= 3'd0;
            vt_out           <= 5'd0;
            v_out            <= 1'b0;
            fh_out           <= 3'd0;
            ht_out           <= 5'd0;
            h_out            <= 1'b0;
            s_out            <= 1'b0;
            spr_pt_out       <= 1'b0;
            spr_h_out        <= 1'b0;
            inc_addr_amt_out <= 1'b0;
            nvbl_en_out      <= 1'b0;
            bg_en_out        <= 1'b0;
            spr_en_out       <= 1'b0;
            bg_clip_out      <= 1'b0;
            spr_clip_out     <= 1'b0;
            upd_cntrs_out    <= 1'b0;
            q_byte_sel       <= 1'b0;
        end else begin
            upd_cntrs_out <= 1'b0;
            if (wr_trig) begin
                case (sel_in)
                    3'd0: begin
                        nvbl_en_out      <= cpu_d_in[7];
                        spr_h_out        <= cpu_d_in[5];
                        s_out            <= cpu_d_in[4];
                        spr_pt_out       <= cpu_d_in[3];
                        inc_addr_amt_out <= cpu_d_in[2];
                        v_out            <= cpu_d_in[1];
                        h_out            <= cpu_d_in[0];
                    end
                    3'd1: begin
                        spr_en_out   <= cpu_d_in[4];
                        bg_en_out    <= cpu_d_in[3];
                        spr_clip_out <= cpu_d_in[2];
                        bg_clip_out  <= cpu_d_in[1];
                    end
                    3'd5: begin
                        if (!q_byte_sel) begin
                            fh_out <= cpu_d_in[2:0];
                            ht_out <= cpu_d_in[7:3];
                        end else begin
                            fv_out <= cpu_d_in[2:0];
                            vt_out <= cpu_d_in[7:3];
                        end
                        q_byte_sel <= ~q_byte_sel;
                    end
                    3'd6: begin
                        if (!q_byte_sel) begin
                            fv_out      <= {1'b0, cpu_d_in[5:4]};
                            v_out       <= cpu_d_in[3];
                            h_out       <= cpu_d_in[2];
                            vt_out[4:3] <= cpu_d_in[1:0];
                        end else begin
                            vt_out[2:0]   <= cpu_d_in[7:5];
                            ht_out        <= cpu_d_in[4:0];
                            upd_cntrs_out <= 1'b1;
                        end
                        q_byte_sel <= ~q_byte_sel;
                    end
                    default: ;
                endcase
            end else if (rd_2002) begin
                q_byte_sel <= 1'b0;
            end
        end
    end

    // Sprite RAM pointer: $2003 loads it, $2004 writes post-increment it.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            q_spr_a <= '0;
        end else if (wr_trig && sel_in == 3'd3) begin
            q_spr_a <= cpu_d_in[SPR_RAM_AW-1:0];
        end else if (wr_trig && sel_in == 3'd4) begin
            q_spr_a <= q_spr_a + 1'b1;
        end
    end

    // $2007 read FSM: request held until ack or timeout, buffer on ack.
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            rd_state <= RD_IDLE;
            q_to_cnt <= '0;
            q_rd_buf <= 8'h00;
            q_pal_rd <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (rd_2007_acc) begin
                        rd_state <= RD_REQ;
                        q_to_cnt <= '0;
                        q_pal_rd <= pal_hit;
                    end
                end
                RD_REQ: begin
                    if (vram_rd_ack_in) begin
                        q_rd_buf <= vram_d_in;
                        q_pal_rd <= 1'b0;
                        rd_state <= RD_IDLE;
                    end else if (q_to_cnt == TO_LAST) begin
                        q_pal_rd <= 1'b0;
                        rd_state <= RD_IDLE;
                    end else begin
                        q_to_cnt <= q_to_cnt + 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule
